player_move_scheduler: RTL and testbench
========================================

# player_move_scheduler

Sequences player movement commands into the maze-position datapath. It takes one-cycle command pulses (forward, backward, rotateA, rotateD) from the PS/2 key decoder and buffers them in a small FIFO. At a fixed game-tick rate it executes one command per tick. Forward/backward moves first check the target cell with the maze wall memory over a req/ack handshake. The block owns the player's grid position and heading, which feed the renderer.

## Interface
- X_BITS, 4: width of the grid x coordinate; grid is 2^X_BITS columns
- Y_BITS, 4: width of the grid y coordinate
- START_X, 0: x position loaded at reset
- START_Y, 0: y position loaded at reset
- TICK_DIV, 833333: clock cycles per game tick (60 Hz at 50 MHz); must be ≥ 2
- FIFO_DEPTH, 4: command FIFO entries; power of two
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- forward  in  1  one-cycle pulse: move one cell along heading
- backward  in  1  one-cycle pulse: move one cell opposite heading
- rotateA  in  1  one-cycle pulse: turn left
- rotateD  in  1  one-cycle pulse: turn right
- wall_req  out  1  wall lookup request
- wall_x  out  X_BITS  target cell x; valid while wall_req = 1
- wall_y  out  Y_BITS  target cell y; valid while wall_req = 1
- wall_ack  in  1  lookup complete; sampled only while wall_req = 1
- wall_blocked  in  1  target cell is a wall; valid on the wall_ack cycle
- pos_x  out  X_BITS  player x
- pos_y  out  Y_BITS  player y
- heading  out  2  0 = N (y-1), 1 = E (x+1), 2 = S (y+1), 3 = W (x-1)
- move_done  out  1  one-cycle pulse when a command completes
- move_blocked  out  1  one-cycle pulse with move_done when a move was refused
- cmd_dropped  out  1  one-cycle pulse when an input pulse is discarded because the FIFO is full
- busy  out  1  state ≠ IDLE

## Operation
- Reset values: pos = (START_X, START_Y); heading = 0; FIFO empty; tick counter = 0; tick_pending = 0; state IDLE. All other outputs are 0.
- Enqueue: on any cycle with ≥ 1 command input high, exactly one command is enqueued. Priority is forward > backward > rotateA > rotateD; lower-priority pulses in the same cycle are lost silently.
- FIFO full on an enqueue cycle: the command is dropped and cmd_dropped pulses. A same-cycle pop does not free a slot for that command.
- Tick: the counter runs 0..TICK_DIV-1 and wraps. At the wrap, tick_pending is set. Ticks arriving while tick_pending is already set are not counted.
- IDLE: if tick_pending and the FIFO is non-empty, pop one command, clear tick_pending, and go to DECODE. If the FIFO is empty, tick_pending stays set.
- DECODE:
  - Rotation: heading = heading-1 mod 4 for rotateA, +1 mod 4 for rotateD. Pulse move_done; go to IDLE.
  - Move: compute the target from heading (inverted for backward).
  - Target outside 0..2^N-1 (edges do not wrap): pulse move_done and move_blocked; no request; go to IDLE.
  - Otherwise register wall_x/wall_y, raise wall_req, and go to WALL_WAIT.
- WALL_WAIT: hold wall_req, wall_x and wall_y stable until the wall_ack cycle.
  - On ack: wall_req drops next cycle. If wall_blocked = 0, pos is loaded with the target. move_done pulses; move_blocked = wall_blocked. Go to IDLE.

## Timing
- Pop at the edge ending cycle T; DECODE is active in T+1.
- Rotation or out-of-bounds move: new heading and move_done are visible in T+2.
- In-bounds move: wall_req is high from T+2 through ack cycle A inclusive. At A+1: wall_req = 0, pos updated, move_done = 1, state IDLE.
- Throughput is at most one command per tick.
- Reset asserted mid-operation: every register returns to its reset value at that edge. wall_req = 0 the following cycle and the FIFO is flushed.

## Configuration
- PLAYER_SCHED_TIMEOUT_EN defined:
  - WALL_WAIT counts cycles. If 256 cycles pass without wall_ack, the move completes as blocked: move_done and move_blocked pulse, wall_req drops, pos is unchanged.
  - A late wall_ack is ignored because wall_req is low.
- Undefined: WALL_WAIT waits indefinitely for wall_ack.

## Test plan
- TICK_DIV=4, reset, then a single rotateD pulse: heading 0→1 and one move_done pulse within 2 cycles of the next tick wrap; pos stays (0,0).
- START=(3,3), heading 0, forward; ack in the 3rd req cycle with wall_blocked=0: wall_x/wall_y = (3,2) stable while req high; pos=(3,2) and move_done the cycle after ack.
- Same as above but wall_blocked=1: pos stays (3,3); move_done=move_blocked=1 for one cycle.
- START=(0,0), heading 0, forward: no wall_req; move_blocked pulses (edge, no wrap).
- FIFO_DEPTH=4, six pulses (forward, backward, rotateA, rotateD, rotateA, rotateD) with no ticks elapsed: cmd_dropped pulses exactly on the 5th and 6th; later the four queued commands execute one per tick, in order.
- forward and rotateA high in the same cycle: only forward is enqueued. Separately, reset asserted in WALL_WAIT: wall_req = 0 next cycle, pos = START, FIFO empty. With PLAYER_SCHED_TIMEOUT_EN and no ack: move_blocked pulses after 256 cycles.

Source files
------------

// File: rtl/player_move_scheduler.sv
// player_move_scheduler
// Queues one-cycle movement pulses from the key decoder and executes at most
// one command per game tick. Forward/backward moves ask the wall memory about
// the target cell over a req/ack handshake before updating the position.
// Owns the player grid position and heading that feed the renderer.
//
// Build option: define PLAYER_SCHED_TIMEOUT_EN to give up on a wall lookup
// after 256 cycles without wall_ack (the move then completes as blocked).
// Without it the lookup waits indefinitely.
//
// State table
//   state       | meaning
//   S_IDLE      | waiting for a pending tick with a queued command
//   S_DECODE    | popped command: rotate, refuse at grid edge, or start lookup
//   S_WALL_WAIT | wall_req held high until wall_ack (or timeout when enabled)

module player_move_scheduler #(
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 4,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int TICK_DIV   = 833333,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              forward,
    input  logic              backward,
    input  logic              rotateA,
    input  logic              rotateD,
    output logic              wall_req,
    output logic [X_BITS-1:0] wall_x,
    output logic [Y_BITS-1:0] wall_y,
    input  logic              wall_ack,
    input  logic              wall_blocked,
    output logic [X_BITS-1:0] pos_x,
    output logic [Y_BITS-1:0] pos_y,
    output logic [1:0]        heading,
    output logic              move_done,
    output logic              move_blocked,
    output logic              cmd_dropped,
    output logic              busy
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] CMD_FWD  = 2'd0;
    localparam logic [1:0] CMD_BWD  = 2'd1;
    localparam logic [1:0] CMD_ROTA = 2'd2;
    localparam logic [1:0] CMD_ROTD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_WALL_WAIT = 2'd2
    } state_t;

    state_t state;

    // command FIFO
    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       fifo_full;
    logic       push;
    logic       pop;

    // tick generation
    logic [TICK_W-1:0] tick_count;
    logic              tick_wrap;
    logic              tick_pending;

    // command being executed
    logic [1:0]        cur_cmd;
    logic [1:0]        move_dir;
    logic [X_BITS-1:0] tgt_x;
    logic [Y_BITS-1:0] tgt_y;
    logic              tgt_outside;

`ifdef PLAYER_SCHED_TIMEOUT_EN
    logic [7:0] timeout_count;
`endif

    // Input priority encoder: only the highest-priority pulse of a cycle survives.
    always_comb begin
        cmd_valid = forward | backward | rotateA | rotateD;
        cmd_code  = CMD_ROTD;
        if (forward) begin
            cmd_code = CMD_FWD;
        end else if (backward) begin
            cmd_code = CMD_BWD;
        end else if (rotateA) begin
            cmd_code = CMD_ROTA;
        end
    end

    // Fullness is judged before any same-cycle pop, so a pop never frees room
    // for the command arriving in that cycle.
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state == S_IDLE) && tick_pending && (fifo_count != '0);
    assign tick_wrap = (tick_count == TICK_W'(TICK_DIV - 1));

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_code;
        end
    end

    // FIFO pointers, occupancy and the drop indication.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            cmd_dropped <= 1'b0;
        end else begin
            cmd_dropped <= cmd_valid && fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Game tick counter; a wrap latches one pending tick, extra wraps are lost.
    // A wrap on the same edge as a pop re-arms the tick rather than losing it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tick_count   <= '0;
            tick_pending <= 1'b0;
        end else begin
            if (tick_wrap) begin
                tick_count <= '0;
            end else begin
                tick_count <= tick_count + TICK_W'(1);
            end
            if (tick_wrap) begin
                tick_pending <= 1'b1;
            end else if (pop) begin
                tick_pending <= 1'b0;
            end
        end
    end

    // Target cell of the decoded move; edges of the grid do not wrap.
    always_comb begin
        move_dir    = (cur_cmd == CMD_BWD) ? (heading + 2'd2) : heading;
        tgt_x       = pos_x;
        tgt_y       = pos_y;
        tgt_outside = 1'b0;
        case (move_dir)
            2'd0: begin
                if (pos_y == '0) tgt_outside = 1'b1;
                else             tgt_y = pos_y - Y_BITS'(1);
            end
            2'd1: begin
                if (pos_x == '1) tgt_outside = 1'b1;
                else             tgt_x = pos_x + X_BITS'(1);
            end
            2'd2: begin
                if (pos_y == '1) tgt_outside = 1'b1;
                else             tgt_y = pos_y + Y_BITS'(1);
            end
            default: begin
                if (pos_x == '0) tgt_outside = 1'b1;
                else             tgt_x = pos_x - X_BITS'(1);
            end
        endcase
    end

    // Command sequencer with registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            cur_cmd      <= CMD_FWD;
            pos_x        <= X_BITS'(START_X);
            pos_y        <= Y_BITS'(START_Y);
            heading      <= 2'd0;
            wall_req     <= 1'b0;
            wall_x       <= '0;
            wall_y       <= '0;
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
`ifdef PLAYER_SCHED_TIMEOUT_EN
            timeout_count <= '0;
`endif
        end else begin
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_cmd <= fifo_mem[rd_ptr];
                        state   <= S_DECODE;
                        busy    <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (cur_cmd == CMD_ROTA) begin
                        heading   <= heading - 2'd1;
                        move_done <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else if (cur_cmd == CMD_ROTD) begin
                        heading   <= heading + 2'd1;
                        move_done <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else if (tgt_outside) begin
                        move_done    <= 1'b1;
                        move_blocked <= 1'b1;
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                    end else begin
                        wall_x   <= tgt_x;
                        wall_y   <= tgt_y;
                        wall_req <= 1'b1;
                        state    <= S_WALL_WAIT;
`ifdef PLAYER_SCHED_TIMEOUT_EN
                        timeout_count <= '0;
`endif
                    end
                end
                S_WALL_WAIT: begin
                    if (wall_ack) begin
                        wall_req     <= 1'b0;
                        move_done    <= 1'b1;
                        move_blocked <= wall_blocked;
                        if (!wall_blocked) begin
                            pos_x <= wall_x;
                            pos_y <= wall_y;
                        end
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
`ifdef PLAYER_SCHED_TIMEOUT_EN
                    else if (timeout_count == 8'hFF) begin
                        wall_req     <= 1'b0;
                        move_done    <= 1'b1;
                        move_blocked <= 1'b1;
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                    end
`endif
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    wall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_move_scheduler.sv
// Bench for player_move_scheduler: a command-level model tracks position,
// heading, the command queue and tick bookkeeping, and is compared against the
// DUT every cycle; directed scenarios add literal expectations on top.
`timescale 1ns/1ps
module tb_player_move_scheduler;
    localparam int XB = 4;
    localparam int YB = 4;
    localparam int SX = 3;
    localparam int SY = 3;
    localparam int TD = 4;
    localparam int FD = 4;
    localparam int GRID_X = 1 << XB;
    localparam int GRID_Y = 1 << YB;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic forward = 1'b0, backward = 1'b0, rotateA = 1'b0, rotateD = 1'b0;
    logic wall_ack = 1'b0, wall_blocked = 1'b0;
    logic          wall_req;
    logic [XB-1:0] wall_x, pos_x;
    logic [YB-1:0] wall_y, pos_y;
    logic [1:0]    heading;
    logic          move_done, move_blocked, cmd_dropped, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    player_move_scheduler #(
        .X_BITS(XB), .Y_BITS(YB), .START_X(SX), .START_Y(SY),
        .TICK_DIV(TD), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .resetn(resetn),
        .forward(forward), .backward(backward), .rotateA(rotateA), .rotateD(rotateD),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_blocked(wall_blocked),
        .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .move_done(move_done), .move_blocked(move_blocked),
        .cmd_dropped(cmd_dropped), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- wall memory responder ----------------
    int ack_at = 1;
    bit blk_cfg = 1'b0;
    bit resp_en = 1'b1;
    int req_cnt = 0;

    always @(negedge clock) begin
        #1;
        if (wall_req === 1'b1 && resp_en) begin
            req_cnt++;
            if (req_cnt >= ack_at) begin
                wall_ack     = 1'b1;
                wall_blocked = blk_cfg;
            end else begin
                wall_ack     = 1'b0;
                wall_blocked = 1'b0;
            end
        end else begin
            req_cnt      = 0;
            wall_ack     = 1'b0;
            wall_blocked = 1'b0;
        end
    end

    // ---------------- behavioural model ----------------
    int m_px, m_py, m_head, m_tick, m_tx, m_ty, m_wait, m_job;
    bit m_pend, m_busy, m_dec, m_req, m_done, m_blk, m_drop, m_valid = 1'b0;
    int m_q[$];
    bit any_cmd, q_full, do_pop, do_wrap;
    int code, dir, tx, ty;

    // Inputs change only just after a falling edge, so at the falling edge
    // they still hold what the preceding rising edge saw.
    always @(negedge clock) begin
        if (resetn === 1'b0) begin
            m_px = SX; m_py = SY; m_head = 0; m_tick = 0; m_pend = 0;
            m_busy = 0; m_dec = 0; m_req = 0; m_done = 0; m_blk = 0; m_drop = 0;
            m_tx = 0; m_ty = 0; m_wait = 0; m_job = 0;
            m_q.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            any_cmd = forward | backward | rotateA | rotateD;
            code    = forward ? 0 : backward ? 1 : rotateA ? 2 : 3;
            q_full  = (m_q.size() == FD);
            do_pop  = !m_busy && m_pend && (m_q.size() > 0);
            do_wrap = (m_tick == TD - 1);
            m_tick  = do_wrap ? 0 : m_tick + 1;
            if (do_wrap) m_pend = 1;
            else if (do_pop) m_pend = 0;
            m_done = 0;
            m_blk  = 0;
            if (m_dec) begin
                m_dec = 0;
                if (m_job == 2 || m_job == 3) begin
                    m_head = (m_job == 2) ? (m_head + 3) % 4 : (m_head + 1) % 4;
                    m_done = 1; m_busy = 0;
                end else begin
                    dir = (m_job == 1) ? (m_head + 2) % 4 : m_head;
                    tx = m_px + ((dir == 1) ? 1 : (dir == 3) ? -1 : 0);
                    ty = m_py + ((dir == 2) ? 1 : (dir == 0) ? -1 : 0);
                    if (tx < 0 || tx >= GRID_X || ty < 0 || ty >= GRID_Y) begin
                        m_done = 1; m_blk = 1; m_busy = 0;
                    end else begin
                        m_tx = tx; m_ty = ty; m_req = 1; m_wait = 0;
                    end
                end
            end else if (m_req) begin
                if (wall_ack) begin
                    m_req = 0; m_done = 1; m_blk = wall_blocked; m_busy = 0;
                    if (!wall_blocked) begin m_px = m_tx; m_py = m_ty; end
                end
`ifdef PLAYER_SCHED_TIMEOUT_EN
                else if (m_wait == 255) begin
                    m_req = 0; m_done = 1; m_blk = 1; m_busy = 0;
                end else begin
                    m_wait++;
                end
`endif
            end
            if (do_pop) begin
                m_job = m_q.pop_front();
                m_dec = 1; m_busy = 1;
            end
            m_drop = any_cmd && q_full;
            if (any_cmd && !q_full) m_q.push_back(code);
        end
        if (m_valid) begin
            chk("pos_x", pos_x, m_px);
            chk("pos_y", pos_y, m_py);
            chk("heading", heading, m_head);
            chk("wall_req", wall_req, m_req);
            if (m_req) begin
                chk("wall_x", wall_x, m_tx);
                chk("wall_y", wall_y, m_ty);
            end
            chk("move_done", move_done, m_done);
            chk("move_blocked", move_blocked, m_blk);
            chk("cmd_dropped", cmd_dropped, m_drop);
            chk("busy", busy, m_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(input bit f, input bit b, input bit a, input bit d);
        forward = f; backward = b; rotateA = a; rotateD = d;
        step();
        forward = 0; backward = 0; rotateA = 0; rotateD = 0;
    endtask

    task automatic wait_done(input string nm, input int budget, output logic blk);
        int n = 0;
        while (move_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_done_seen"}, move_done, 1);
        blk = move_blocked;
        step();
    endtask

    task automatic wait_req(input string nm, input int budget);
        int n = 0;
        while (wall_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_req_seen"}, wall_req, 1);
    endtask

    logic b;
    bit   seq_f [6] = '{1, 0, 0, 0, 0, 0};
    bit   seq_b [6] = '{0, 1, 0, 0, 0, 0};
    bit   seq_a [6] = '{0, 0, 1, 0, 1, 0};
    bit   seq_d [6] = '{0, 0, 0, 1, 0, 1};
    logic exp_blk [5] = '{0, 1, 0, 0, 0};

    initial begin
        #50000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) step();
        chk("rst_pos_x", pos_x, SX);
        chk("rst_pos_y", pos_y, SY);
        chk("rst_heading", heading, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;

        // rotate right then left
        pulse(0, 0, 0, 1);
        wait_done("rotd", 20, b);
        chk("rotd_heading", heading, 1);
        chk("rotd_pos_x", pos_x, 3);
        chk("rotd_pos_y", pos_y, 3);
        chk("rotd_blk", b, 0);
        pulse(0, 0, 1, 0);
        wait_done("rota", 20, b);
        chk("rota_heading", heading, 0);

        // forward north, ack on third request cycle, free cell
        ack_at = 3; blk_cfg = 0;
        pulse(1, 0, 0, 0);
        wait_req("fwd1", 20);
        chk("fwd1_wall_x", wall_x, 3);
        chk("fwd1_wall_y", wall_y, 2);
        wait_done("fwd1", 20, b);
        chk("fwd1_pos_y", pos_y, 2);
        chk("fwd1_blk", b, 0);

        // forward into a wall
        ack_at = 1; blk_cfg = 1;
        pulse(1, 0, 0, 0);
        wait_done("fwdwall", 20, b);
        chk("fwdwall_blk", b, 1);
        chk("fwdwall_pos_y", pos_y, 2);

        // walk to the north edge and bump it
        blk_cfg = 0;
        pulse(1, 0, 0, 0);
        wait_done("fwd2", 20, b);
        pulse(1, 0, 0, 0);
        wait_done("fwd3", 20, b);
        chk("fwd3_pos_y", pos_y, 0);
        pulse(1, 0, 0, 0);
        wait_done("edge", 20, b);
        chk("edge_blk", b, 1);
        chk("edge_pos_y", pos_y, 0);
        chk("edge_noreq", wall_req, 0);
        pulse(0, 1, 0, 0);
        wait_done("bwd", 20, b);
        chk("bwd_pos_y", pos_y, 1);

        // fill the FIFO while a slow lookup is outstanding
        ack_at = 12;
        pulse(1, 0, 0, 0);
        wait_req("slow", 20);
        for (int i = 0; i < 6; i++) begin
            pulse(seq_f[i], seq_b[i], seq_a[i], seq_d[i]);
            chk($sformatf("drop_%0d", i), cmd_dropped, (i >= 4) ? 1 : 0);
        end
        ack_at = 2;
        for (int i = 0; i < 5; i++) begin
            wait_done($sformatf("q%0d", i), 40, b);
            chk($sformatf("q%0d_blk", i), b, exp_blk[i]);
        end
        chk("q_pos_x", pos_x, 3);
        chk("q_pos_y", pos_y, 1);
        chk("q_heading", heading, 0);

        // simultaneous forward and rotateA: only forward runs
        pulse(1, 0, 1, 0);
        wait_done("simul", 20, b);
        chk("simul_pos_y", pos_y, 0);
        repeat (12) step();
        chk("simul_heading", heading, 0);
        chk("simul_idle", busy, 0);

        // reset while waiting on the wall memory, with a command queued
        resp_en = 0;
        pulse(0, 1, 0, 0);
        wait_req("rstww", 20);
        pulse(0, 0, 0, 1);
        resetn = 1'b0;
        step();
        chk("rstww_req", wall_req, 0);
        chk("rstww_pos_x", pos_x, SX);
        chk("rstww_pos_y", pos_y, SY);
        chk("rstww_heading", heading, 0);
        resetn = 1'b1;
        resp_en = 1;
        repeat (12) step();
        chk("rstww_flushed_heading", heading, 0);
        chk("rstww_idle", busy, 0);

`ifdef PLAYER_SCHED_TIMEOUT_EN
        resp_en = 0;
        pulse(1, 0, 0, 0);
        wait_done("tmo", 400, b);
        chk("tmo_blk", b, 1);
        chk("tmo_pos_y", pos_y, SY);
        resp_en = 1;
`endif

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
